dmem_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the single-port, word-wide data memory model.
- Memory model: combinational read; write committed on posedge clk while write-enable is high.
- Shares the memory between the instruction-fetch requester (read-only) and the load/store requester.
- Converts sub-word stores (byte enables) into read-modify-write sequences and flags misaligned accesses.

---
 rtl/dmem_access_ctrl.sv | 107 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates fetch and load/store access to a single-port data memory.
// Sub-word stores are turned into read-modify-write sequences.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_err,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;
  state_t state, next;
  logic last_d, gd, req_any, pick_d, mis, err_n, win_d;
  logic [DATA_W/8-1:0] lat_be;
  logic [DATA_W-1:0] lat_wdata, merged;
  logic [ADDR_W-1:0] sel_addr;

  // D wins a tie unless it won the previous grant
  assign req_any  = if_req | d_req;
  assign pick_d   = d_req & (~if_req | ~last_d);
  assign sel_addr = pick_d ? d_addr : if_addr;
  assign mis      = sel_addr[1:0] != 2'b00;
  assign win_d    = (state == IDLE) ? pick_d : gd;

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_lane
    assign merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (req_any) next = mis ? DONE : !(pick_d && d_we) ? RD :
                                   (&d_be) ? WR : (d_be == '0) ? DONE : RMW_RD;
      RD:      next = DONE;
      RMW_RD:  next = mem_err ? DONE : WR;
      WR:      next = DONE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE) && !reset;
    mem_we = (state == WR) && !reset;
    d_ack  = (state == DONE) && gd && !reset;
    if_ack = (state == DONE) && !gd && !reset;
  end

  // err to report if this cycle is the last before DONE
  assign err_n = (state == IDLE) ? mis : (state == RD || state == RMW_RD) ? mem_err : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d    <= 1'b0;
      gd        <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      if (state == IDLE && req_any) begin
        gd        <= pick_d;
        last_d    <= pick_d;
        lat_be    <= d_be;
        lat_wdata <= d_wdata;
        mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
        if (pick_d && d_we) mem_wdata <= d_wdata;
      end
      if (state == RMW_RD) mem_wdata <= merged;
      if (next == DONE && state != DONE) begin
        if (win_d) begin
          d_err <= err_n;
          if (state == RD) d_rdata <= mem_rdata;
        end else begin
          if_err <= err_n;
          if (state == RD) if_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl with a behavioural memory.
module tb_dmem_access_ctrl;
  logic clk = 0, reset;
  logic if_req, if_ack, if_err, d_req, d_we, d_ack, d_err, mem_we, mem_err, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] d_be;
  logic [31:0] mem [1024];
  logic pre_en;
  logic [9:0] pre_idx;
  logic [31:0] pre_data, last_wa, last_wd;
  int we_cnt = 0, tests = 0, fails = 0;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:12] == 0 && mem_addr[1:0] == 0) ? mem[mem_addr[11:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  task automatic op(input logic is_d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                    input logic [31:0] wdata, input int exp_lat, input logic chk_rd,
                    input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    logic ack;
    @(negedge clk);
    if (is_d) begin d_req = 1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    lat = 0; ack = 0;
    while (!ack && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      ack = is_d ? d_ack : if_ack;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " other_ack"}, {31'b0, is_d ? if_ack : d_ack}, 32'd0);
    if (chk_rd) chk({tag, " rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
    chk({tag, " err"}, {31'b0, is_d ? d_err : if_err}, {31'b0, exp_err});
    d_req = 0; if_req = 0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d_cyc, i_cyc, n, w0;
    int seq [4];
    reset = 1; pre_en = 0; mem_err = 0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    preload(10'h000, 32'h11111111);
    preload(10'h010, 32'h22222222);
    preload(10'h040, 32'hDEADBEEF);
    preload(10'h080, 32'h00000000);
    preload(10'h0C0, 32'h0BADF00D);
    @(negedge clk);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst mem_we", {31'b0, mem_we}, 0);
    chk("rst acks", {30'b0, d_ack, if_ack}, 0);
    chk("rst errs", {30'b0, d_err, if_err}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst if_rdata", if_rdata, 0);

    // both requesters present as reset releases: D first, then IF
    if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h40;
    reset = 0;
    d_cyc = 0; i_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (d_ack) begin d_cyc = c; chk("arb d_rdata", d_rdata, 32'h22222222); d_req = 0; end
      if (if_ack) begin i_cyc = c; chk("arb if_rdata", if_rdata, 32'h11111111); if_req = 0; end
    end
    chk("arb d_ack cycle", 32'(d_cyc), 2);
    chk("arb if_ack cycle", 32'(i_cyc), 5);

    @(negedge clk);
    if_req = 1; d_req = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (d_ack) begin seq[n] = 1; n++; end
      if (if_ack && n < 4) begin seq[n] = 2; n++; end
    end
    if_req = 0; d_req = 0;
    @(posedge clk);
    chk("alt count", 32'(n), 4);
    chk("alt grant0", 32'(seq[0]), 1);
    chk("alt grant1", 32'(seq[1]), 2);
    chk("alt grant2", 32'(seq[2]), 1);
    chk("alt grant3", 32'(seq[3]), 2);

    w0 = we_cnt;
    op(1, 0, 4'h0, 32'h100, 0, 2, 1, 32'hDEADBEEF, 0, "ld100");
    chk("ld100 no write", 32'(we_cnt - w0), 0);

    w0 = we_cnt;
    op(1, 1, 4'hF, 32'h200, 32'h12345678, 2, 0, 0, 0, "st_full");
    chk("st_full writes", 32'(we_cnt - w0), 1);
    chk("st_full addr", last_wa, 32'h200);
    op(1, 0, 4'h0, 32'h200, 0, 2, 1, 32'h12345678, 0, "ld200a");

    w0 = we_cnt;
    op(1, 1, 4'b0010, 32'h200, 32'h0000AB00, 3, 0, 0, 0, "st_part");
    chk("st_part writes", 32'(we_cnt - w0), 1);
    chk("st_part wdata", last_wd, 32'h1234AB78);
    op(1, 0, 4'h0, 32'h200, 0, 2, 1, 32'h1234AB78, 0, "ld200b");

    w0 = we_cnt;
    op(1, 0, 4'h0, 32'h102, 0, 1, 0, 0, 1, "ld_mis");
    op(0, 0, 4'h0, 32'h3, 0, 1, 0, 0, 1, "if_mis");
    op(0, 0, 4'h0, 32'h100, 0, 2, 1, 32'hDEADBEEF, 0, "if_ld");
    op(1, 1, 4'h0, 32'h200, 32'hFFFFFFFF, 1, 0, 0, 0, "st_be0");
    chk("err paths no write", 32'(we_cnt - w0), 0);

    mem_err = 1;
    op(1, 1, 4'b0001, 32'h200, 32'h000000FF, 2, 0, 0, 1, "st_rmw_err");
    mem_err = 0;
    chk("rmw_err no write", 32'(we_cnt - w0), 0);
    chk("mem200 kept", mem[10'h080], 32'h1234AB78);

    // reset while the store sits in WR
    w0 = we_cnt;
    @(negedge clk);
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    chk("rstwr busy in WR", {31'b0, busy}, 1);
    chk("rstwr mem_we in WR", {31'b0, mem_we}, 1);
    reset = 1; #1;
    chk("rstwr mem_we gated", {31'b0, mem_we}, 0);
    @(posedge clk); #1;
    chk("rstwr busy after", {31'b0, busy}, 0);
    chk("rstwr no ack", {30'b0, d_ack, if_ack}, 0);
    d_req = 0; reset = 0;
    @(posedge clk); #1;
    chk("rstwr no write", 32'(we_cnt - w0), 0);
    chk("rstwr mem kept", mem[10'h0C0], 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
